fizzbuzz_gen: RTL and testbench

Parametrised FizzBuzz sequence generator: on a start pulse it emits the terms 1..MAX_CYCLES, one per accepted beat, each tagged with mutually exclusive fizz/buzz/fizzbuzz flags. Divisibility is tracked with wrapping modulo counters, with no dividers. A valid/ready output handshake allows a downstream consumer to stall the stream. It replaces the fixed free-running FizzBuzz model and is the generator used by the FizzBuzz benches and any consumer needing a back-pressurable sequence.

---
 rtl/fizzbuzz_gen_if.sv | 22 ++
 rtl/fizzbuzz_gen.sv | 147 ++++++++++++++
 tb/tb_fizzbuzz_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fizzbuzz_gen_if.sv
// Output stream of the FizzBuzz generator: one term per accepted beat plus its
// mutually exclusive divisibility flags, with valid/ready back-pressure.
interface fizzbuzz_gen_if #(
  parameter int CNT_W = 5
);
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             fizz;
  logic             buzz;
  logic             fizzbuzz;

  modport master (
    output out_valid, out_count, fizz, buzz, fizzbuzz,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_count, fizz, buzz, fizzbuzz,
    output out_ready
  );
endinterface

// File: rtl/fizzbuzz_gen.sv
// Back-pressurable FizzBuzz generator: emits terms 1..MAX_CYCLES per start pulse.
// Optional macro FIZZBUZZ_GEN_RUNTIME_DIV_EN adds runtime fizz_div/buzz_div ports.
module fizzbuzz_gen #(
  parameter int MAX_CYCLES = 30,
  parameter int FIZZ_DIV   = 3,
  parameter int BUZZ_DIV   = 5,
  parameter int DIV_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
`ifdef FIZZBUZZ_GEN_RUNTIME_DIV_EN
  input  logic [DIV_W-1:0] fizz_div,
  input  logic [DIV_W-1:0] buzz_div,
`endif
  fizzbuzz_gen_if.master   m,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W   = $clog2(MAX_CYCLES + 1);
  localparam int MAX_DIV = (FIZZ_DIV > BUZZ_DIV) ? FIZZ_DIV : BUZZ_DIV;
  localparam int MIN_W   = $clog2(MAX_DIV + 1);
  localparam int MOD_W   = (MIN_W > DIV_W) ? MIN_W : DIV_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MOD_W-1:0] mod_f_q, mod_f_d, mod_b_q, mod_b_d;
  logic             fizz_q, buzz_q, fizzbuzz_q;
  logic             fizz_d, buzz_d, fizzbuzz_d;
  logic             load;
  logic [MOD_W-1:0] fdiv_load, bdiv_load, fdiv_run, bdiv_run;

  function automatic logic [MOD_W-1:0] mod_init(input logic [MOD_W-1:0] d);
    return (d == MOD_W'(1)) ? '0 : MOD_W'(1);
  endfunction

  function automatic logic [MOD_W-1:0] mod_step(input logic [MOD_W-1:0] v,
                                                input logic [MOD_W-1:0] d);
    return (v == d - 1'b1) ? '0 : v + 1'b1;
  endfunction

`ifdef FIZZBUZZ_GEN_RUNTIME_DIV_EN
  logic [MOD_W-1:0] fdiv_q, bdiv_q;

  // A zero divisor would never wrap; treat it as 1 so every term matches.
  function automatic logic [MOD_W-1:0] sanitize_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? MOD_W'(1) : MOD_W'(d);
  endfunction

  assign fdiv_load = sanitize_div(fizz_div);
  assign bdiv_load = sanitize_div(buzz_div);
  assign fdiv_run  = fdiv_q;
  assign bdiv_run  = bdiv_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fdiv_q <= MOD_W'(1);
      bdiv_q <= MOD_W'(1);
    end else if (load) begin
      fdiv_q <= fdiv_load;
      bdiv_q <= bdiv_load;
    end
  end
`else
  assign fdiv_load = MOD_W'(FIZZ_DIV);
  assign bdiv_load = MOD_W'(BUZZ_DIV);
  assign fdiv_run  = fdiv_load;
  assign bdiv_run  = bdiv_load;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    mod_f_d = mod_f_q;
    mod_b_d = mod_b_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          load    = 1'b1;
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
          mod_f_d = mod_init(fdiv_load);
          mod_b_d = mod_init(bdiv_load);
        end
      end
      RUN: begin
        if (valid_q && m.out_ready) begin
          if (cnt_q == CNT_W'(MAX_CYCLES)) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            mod_f_d = mod_step(mod_f_q, fdiv_run);
            mod_b_d = mod_step(mod_b_q, bdiv_run);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flags follow the next residues so they register in step with out_count.
  always_comb begin
    fizzbuzz_d = valid_d && (mod_f_d == '0) && (mod_b_d == '0);
    fizz_d     = valid_d && (mod_f_d == '0) && (mod_b_d != '0);
    buzz_d     = valid_d && (mod_b_d == '0) && (mod_f_d != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      mod_f_q    <= '0;
      mod_b_q    <= '0;
      fizz_q     <= 1'b0;
      buzz_q     <= 1'b0;
      fizzbuzz_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      mod_f_q    <= mod_f_d;
      mod_b_q    <= mod_b_d;
      fizz_q     <= fizz_d;
      buzz_q     <= buzz_d;
      fizzbuzz_q <= fizzbuzz_d;
    end
  end

  assign m.out_valid = valid_q;
  assign m.out_count = cnt_q;
  assign m.fizz      = fizz_q;
  assign m.buzz      = buzz_q;
  assign m.fizzbuzz  = fizzbuzz_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_fizzbuzz_gen.sv
// Scoreboard bench for fizzbuzz_gen: expected beats are queued at each start,
// a negedge monitor pops and compares every accepted beat.
module tb_fizzbuzz_gen;

  localparam int MAXC = 30;
  localparam int CW   = $clog2(MAXC + 1);

  typedef struct packed {
    logic [7:0] cnt;
    logic       fz;
    logic       bz;
    logic       fb;
  } beat_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic busy, done, busy1, done1;
  logic rand_mode = 1'b0;

  fizzbuzz_gen_if #(.CNT_W(CW)) bus ();
  fizzbuzz_gen_if #(.CNT_W(1))  bus1 ();

`ifdef FIZZBUZZ_GEN_RUNTIME_DIV_EN
  logic [7:0] fizz_div = 8'd3;
  logic [7:0] buzz_div = 8'd5;
  logic [7:0] fizz_div1 = 8'd1;
  logic [7:0] buzz_div1 = 8'd1;
`endif

  fizzbuzz_gen #(.MAX_CYCLES(MAXC), .FIZZ_DIV(3), .BUZZ_DIV(5), .DIV_W(8)) dut (
    .clk(clk), .resetn(resetn), .start(start),
`ifdef FIZZBUZZ_GEN_RUNTIME_DIV_EN
    .fizz_div(fizz_div), .buzz_div(buzz_div),
`endif
    .m(bus), .busy(busy), .done(done)
  );

  fizzbuzz_gen #(.MAX_CYCLES(1), .FIZZ_DIV(1), .BUZZ_DIV(1), .DIV_W(8)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1),
`ifdef FIZZBUZZ_GEN_RUNTIME_DIV_EN
    .fizz_div(fizz_div1), .buzz_div(buzz_div1),
`endif
    .m(bus1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  beat_t exp_q[$];

  // Hand-computed flag patterns: '-' none, F fizz, B buzz, X fizzbuzz.
  string pat_3_5  = "--F-BF--FB-F--X";
  string pat_2_7  = "-F-F-FBF-F-F-X";

  function automatic void chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  function automatic longint pack(input beat_t b);
    return longint'(b);
  endfunction

  task automatic push_run(input string pat);
    beat_t b;
    byte   c;
    for (int n = 1; n <= MAXC; n++) begin
      c     = pat[(n - 1) % pat.len()];
      b.cnt = 8'(n);
      b.fz  = (c == "F");
      b.bz  = (c == "B");
      b.fb  = (c == "X");
      exp_q.push_back(b);
    end
  endtask

  task automatic issue_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Ready driver: held high, or a fresh coin toss each cycle.
  initial begin
    bus.out_ready  = 1'b1;
    bus1.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor and scoreboard.
  initial begin : monitor
    beat_t cur, held_b, e;
    logic  held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        cur.cnt = 8'(bus.out_count);
        cur.fz  = bus.fizz;
        cur.bz  = bus.buzz;
        cur.fb  = bus.fizzbuzz;
        if (done) done_cnt++;
        if (held) chk("stall_hold", pack(cur), pack(held_b));
        held = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", pack(cur), 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat", pack(cur), pack(e));
          end
        end else if (bus.out_valid) begin
          held   = 1'b1;
          held_b = cur;
        end else begin
          chk("idle_flags", {cur.fz, cur.bz, cur.fb}, 0);
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : stim
    int cyc;
    int d0;
    int found;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_count", bus.out_count, 0);
    chk("rst_flags", {bus.fizz, bus.buzz, bus.fizzbuzz}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    resetn = 1'b1;

    // Test 1: full run with ready held high, exact done timing
    d0 = done_cnt;
    push_run(pat_3_5);
    issue_start();
    wait_done(100, cyc);
    chk("t1_done_cycle", cyc, MAXC);
    @(negedge clk);
    chk("t1_after_done", {done, busy, bus.out_valid}, 0);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_queue_left", exp_q.size(), 0);

    // Test 2: random back-pressure
    rand_mode = 1'b1;
    push_run(pat_3_5);
    issue_start();
    wait_done(400, cyc);
    chk("t2_done_seen", (cyc >= 0), 1);
    rand_mode = 1'b0;
    @(negedge clk);
    chk("t2_queue_left", exp_q.size(), 0);

    // Test 3: start held through RUN and DONE
    d0 = done_cnt;
    push_run(pat_3_5);
    push_run(pat_3_5);
    @(posedge clk); #1 start = 1'b1;
    wait_done(100, cyc);
    chk("t3_done1_seen", (cyc >= 0), 1);
    @(negedge clk);
    chk("t3_idle_gap", {busy, bus.out_valid}, 0);
    @(negedge clk);
    chk("t3_restart", {busy, bus.out_valid, 8'(bus.out_count)}, {2'b11, 8'd1});
    start = 1'b0;
    wait_done(100, cyc);
    chk("t3_done2_seen", (cyc >= 0), 1);
    @(negedge clk);
    chk("t3_done_pulses", done_cnt - d0, 2);
    chk("t3_queue_left", exp_q.size(), 0);

    // Test 4: reset mid-run at beat 12
    push_run(pat_3_5);
    issue_start();
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_count == CW'(12)) begin
        found = 1;
        break;
      end
    end
    chk("t4_beat12_seen", found, 1);
    #1 resetn = 1'b0;
    #1;
    chk("t4_async_clear", {bus.out_valid, 8'(bus.out_count), bus.fizz, bus.buzz,
                           bus.fizzbuzz, busy, done}, 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_idle_after", {busy, bus.out_valid}, 0);
    push_run(pat_3_5);
    issue_start();
    wait_done(100, cyc);
    chk("t4_rerun_done", (cyc >= 0), 1);
    @(negedge clk);
    chk("t4_queue_left", exp_q.size(), 0);

    // Test 5: MAX_CYCLES=1 with both divisors 1
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("t5_beat", {bus1.out_valid, bus1.out_count, bus1.fizz, bus1.buzz,
                    bus1.fizzbuzz, done1}, 6'b110010);
    @(negedge clk);
    chk("t5_done", {done1, bus1.out_valid, bus1.fizzbuzz}, 3'b100);
    @(negedge clk);
    chk("t5_idle", {done1, busy1}, 0);

`ifdef FIZZBUZZ_GEN_RUNTIME_DIV_EN
    // Test 6: runtime divisors 2/7, fizz_div changed mid-run is ignored
    fizz_div = 8'd2;
    buzz_div = 8'd7;
    push_run(pat_2_7);
    issue_start();
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_count == CW'(5)) begin
        found = 1;
        break;
      end
    end
    chk("t6_mid_seen", found, 1);
    fizz_div = 8'd3;
    wait_done(100, cyc);
    chk("t6_done_seen", (cyc >= 0), 1);
    @(negedge clk);
    chk("t6_queue_left", exp_q.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
